// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with guard blanking between digits.
// Optional leading-zero suppression: define BCD_DISPLAY_LEADING_ZERO_BLANK_EN.

module bcd_seg_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // {g,f,e,d,c,b,a}, active-low; non-BCD codes render as a minus sign
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

module bcd_display_scanner #(
  parameter int DIGIT_COUNT = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DIGIT_COUNT-1:0][3:0] digits,
  input  logic [DIGIT_COUNT-1:0]      dp_mask,
  output logic [6:0]                  segments,
  output logic                        dp,
  output logic [DIGIT_COUNT-1:0]      anodes,
  output logic                        frame
);
  localparam int SLOT_MAX = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CW       = $clog2(SLOT_MAX + 1);
  localparam int IW       = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] FRAME_PRE  = CW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_COUNT - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [DIGIT_COUNT-1:0][3:0]   shadow_dig;
  logic [DIGIT_COUNT-1:0]        shadow_dp;
  logic [DIGIT_COUNT-1:0][6:0]   dec_seg;
  logic                          lit;

  // one decoder per shadow digit; the scan only muxes finished patterns
  bcd_seg_decode u_dec [DIGIT_COUNT-1:0] (
    .bcd (shadow_dig),
    .seg (dec_seg)
  );

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
  logic [DIGIT_COUNT-1:0] blank_d, blank_q;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_d    = '0;
    for (int i = DIGIT_COUNT - 1; i >= 1; i--) begin
      zero_above = zero_above && (digits[i] == 4'd0);
      blank_d[i] = zero_above && !dp_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)    blank_q <= '0;
    else if (load) blank_q <= blank_d;
  end

  assign lit = !blank_q[idx];
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_dig <= digits;
      shadow_dp  <= dp_mask;
    end
  end

  // outputs are registered alongside the state so they change only on slot edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= '0;
      segments <= 7'h7F;
      dp       <= 1'b1;
      anodes   <= '1;
      frame    <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        BLANK: begin
          if (cnt == GUARD_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            if (lit) begin
              anodes   <= ~(DIGIT_COUNT'(1) << idx);
              segments <= dec_seg[idx];
              dp       <= ~shadow_dp[idx];
            end
            frame <= (REFRESH_DIV == 1) && (idx == IDX_LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            anodes   <= '1;
            segments <= 7'h7F;
            dp       <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            frame <= (REFRESH_DIV >= 2) && (cnt == FRAME_PRE) && (idx == IDX_LAST);
          end
        end
        default: state <= BLANK;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised + directed bench for bcd_display_scanner against a slot-position reference model.
module tb_bcd_display_scanner;
  localparam int DC = 4;
  localparam int RD = 4;
  localparam int GD = 2;
  localparam int S  = GD + RD;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load = 1'b0;
  logic [DC-1:0][3:0] digits = '0;
  logic [DC-1:0]   dp_mask = '0;
  logic [6:0]      segments;
  logic            dp;
  logic [DC-1:0]   anodes;
  logic            frame;

  bcd_display_scanner #(.DIGIT_COUNT(DC), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_mask(dp_mask),
    .segments(segments), .dp(dp), .anodes(anodes), .frame(frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: edges since reset release and the shadow contents
  int          t = 0;
  int          cur = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_lit = 1'b1;
  logic [6:0]  tab [16];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dm, input logic rst);
    logic       drv;
    int         u;
    logic [3:0] an_exp;
    load = ld; digits = dg; dp_mask = dm; reset = rst;
    @(posedge clk);
    if (!rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_blank = '0;
    end else begin
      t++;
      if (t % S == GD) begin
        cur   = (t / S) % DC;
        e_seg = tab[(m_dig >> (4 * cur)) & 16'hF];
        e_dp  = ~m_dp[cur];
        e_lit = !m_blank[cur];
      end
      if (ld) begin
        m_dig = dg; m_dp = dm; m_blank = '0;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DC; i++)
          m_blank[i] = ((dg >> (4 * i)) == 16'd0) && !dm[i];
`endif
      end
    end
    #1;
    load = 1'b0;
    u   = t % S;
    drv = (u >= GD) && e_lit;
    an_exp = drv ? ~(4'b0001 << cur) : 4'hF;
    chk("anodes",   16'(anodes),   16'(an_exp));
    chk("segments", 16'(segments), drv ? 16'(e_seg) : 16'h7F);
    chk("dp",       16'(dp),       drv ? 16'(e_dp) : 16'h1);
    chk("frame",    16'(frame),    16'((u == S - 1) && ((t / S) % DC == DC - 1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, digits, dp_mask, 1'b1);
  endtask

  // advance until the next edge lands on position u of digit d's slot
  task automatic go_to(input int d, input int u);
    int k;
    k = 0;
    while (!(((t + 1) % S == u) && (((t + 1) / S) % DC == d)) && k < 3 * S * DC) begin
      idle(1);
      k++;
    end
    total++;
    if (k >= 3 * S * DC) begin
      bad++;
      $error("FAIL go_to d=%0d u=%0d not reached", d, u);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tab[i] = 7'b0111111;
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100; tab[3] = 7'b0110000;
    tab[4] = 7'b0011001; tab[5] = 7'b0010010; tab[6] = 7'b0000010; tab[7] = 7'b1111000;
    tab[8] = 7'b0000000; tab[9] = 7'b0010000;

    // reset state, then first frame showing zeros
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    idle(8);

    // scan order, decode and dp
    step(1'b1, 16'h1234, 4'b0100, 1'b1);
    idle(2 * S * DC);

    // no tearing: load during digit 0 drive
    step(1'b1, 16'h0000, 4'h0, 1'b1);
    go_to(0, GD + 1);
    step(1'b1, 16'h9999, 4'h0, 1'b1);
    idle(S * DC);

    // load coincident with BLANK->DRIVE edge
    go_to(1, GD);
    step(1'b1, 16'h5678, 4'b0011, 1'b1);
    idle(S * DC);

    // invalid BCD
    step(1'b1, 16'hF00A, 4'h0, 1'b1);
    idle(S * DC);

    // reset mid-scan during digit 2 drive, then restart
    go_to(2, GD + 1);
    step(1'b1, 16'h4321, 4'hF, 1'b0);
    idle(S * DC);

    // leading zeros (lit when blanking is off, dark when on)
    step(1'b1, 16'h0050, 4'h0, 1'b1);
    idle(S * DC);
    step(1'b1, 16'h0000, 4'h0, 1'b1);
    idle(S * DC);
    step(1'b1, 16'h0005, 4'b0100, 1'b1);
    idle(S * DC);

    // random loads, including back-to-back recaptures
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 1'b1);
      else
        idle(1);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 4'($urandom), 1'b1);
    idle(2 * S * DC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
